// File: rtl/boot_uart_loader.sv
// UART boot loader: parses a 32-bit little-endian word-count header, then packs
// little-endian data bytes into words and strobes them into SRAM via the boot port.
module boot_uart_loader #(
  parameter int              DATA_WIDTH     = 32,
  parameter int              ADDR_WIDTH     = 20,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter longint unsigned MAX_WORDS      = (64'd1 << ADDR_WIDTH) - BASE_ADDR,
  parameter int unsigned     TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_start,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic                  boot_mode,
  output logic                  boot_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] boot_mem_addr,
  output logic [DATA_WIDTH-1:0] boot_mem_rd_data,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic [31:0]           words_loaded
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {IDLE, LEN, DATA, FLUSH, DONE, ERROR} state_t;

  state_t                state, state_nx;
  logic [31:0]           len;
  logic [1:0]            hdr_cnt;
  logic [BCW-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0] word;
  logic [31:0]           tcnt;

  logic [31:0]           len_nx;
  logic [DATA_WIDTH-1:0] word_nx;
  logic                  start, byte_in, timeout, word_done, last_word;

  // Bytes enter at the top and shift down, so the first byte ends up in bits 7:0.
  assign len_nx  = {uart_rx_data, len[31:8]};
  assign word_nx = (word >> 8) | (DATA_WIDTH'(uart_rx_data) << (DATA_WIDTH - 8));

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    byte_in   = 1'b0;
    timeout   = 1'b0;
    word_done = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        start = boot_start;
        if (boot_start) state_nx = LEN;
      end
      LEN: begin
        byte_in = uart_rx_valid;
        timeout = !uart_rx_valid && (tcnt == TIMEOUT_CYCLES - 1);
        if (timeout)
          state_nx = ERROR;
        else if (uart_rx_valid && hdr_cnt == 2'd3) begin
          if (len_nx == 32'd0)                         state_nx = DONE;
          else if ({32'd0, len_nx} > 64'(MAX_WORDS))   state_nx = ERROR;
          else                                         state_nx = DATA;
        end
      end
      DATA: begin
        byte_in   = uart_rx_valid;
        timeout   = !uart_rx_valid && (tcnt == TIMEOUT_CYCLES - 1);
        word_done = uart_rx_valid && (byte_cnt == BCW'(BPW - 1));
        last_word = word_done && (words_loaded + 32'd1 == len);
        if (timeout)        state_nx = ERROR;
        else if (last_word) state_nx = FLUSH;
      end
      FLUSH:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      len              <= '0;
      hdr_cnt          <= '0;
      byte_cnt         <= '0;
      word             <= '0;
      tcnt             <= '0;
      boot_mode        <= 1'b0;
      boot_mem_wr_en   <= 1'b0;
      boot_mem_addr    <= '0;
      boot_mem_rd_data <= '0;
      boot_done        <= 1'b0;
      boot_error       <= 1'b0;
      words_loaded     <= '0;
    end else begin
      state          <= state_nx;
      boot_mode      <= (state_nx == LEN) || (state_nx == DATA) || (state_nx == FLUSH);
      boot_done      <= (state_nx == DONE);
      boot_error     <= (state_nx == ERROR);
      boot_mem_wr_en <= word_done;

      if (start) begin
        len          <= '0;
        hdr_cnt      <= '0;
        byte_cnt     <= '0;
        word         <= '0;
        words_loaded <= '0;
      end

      if (byte_in && state == LEN) begin
        len     <= len_nx;
        hdr_cnt <= hdr_cnt + 2'd1;
      end

      if (byte_in && state == DATA) begin
        word     <= word_nx;
        byte_cnt <= word_done ? '0 : byte_cnt + BCW'(1);
      end

      // Address and data only move on a strobe, so they hold between writes.
      if (word_done) begin
        boot_mem_addr    <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_loaded);
        boot_mem_rd_data <= word_nx;
        words_loaded     <= words_loaded + 32'd1;
      end

      if (start || byte_in)
        tcnt <= '0;
      else if (state == LEN || state == DATA)
        tcnt <= tcnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_boot_uart_loader.sv
// Randomized directed bench for boot_uart_loader; expected words are packed from
// the byte stream in the bench and compared against the captured write strobes.
module tb_boot_uart_loader;

  localparam int              DW   = 32;
  localparam int              AW   = 20;
  localparam int              BPW  = DW / 8;
  localparam int              TO   = 100;
  localparam longint unsigned MAXW = 64'd1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   wl;
    logic          bm;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          boot_start = 1'b0;
  logic [7:0]    uart_rx_data = 8'h00;
  logic          uart_rx_valid = 1'b0;
  logic          boot_mode, boot_mem_wr_en, boot_done, boot_error;
  logic [AW-1:0] boot_mem_addr;
  logic [DW-1:0] boot_mem_rd_data;
  logic [31:0]   words_loaded;

  int  tests = 0;
  int  fails = 0;
  wr_t wq[$];

  boot_uart_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .boot_mode(boot_mode), .boot_mem_wr_en(boot_mem_wr_en),
    .boot_mem_addr(boot_mem_addr), .boot_mem_rd_data(boot_mem_rd_data),
    .boot_done(boot_done), .boot_error(boot_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (boot_mem_wr_en)
      wq.push_back('{boot_mem_addr, boot_mem_rd_data, words_loaded, boot_mode});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hdr(input logic [31:0] n, output bq_t q);
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
  endtask

  task automatic gen_payload(input int n, output bq_t d);
    d = {};
    for (int i = 0; i < n * BPW; i++) d.push_back(8'($urandom));
  endtask

  // The last byte is never followed by a gap, so on return the bench sits at
  // the negedge just after the clock edge that accepted that byte.
  task automatic send_bytes(input bq_t q, input int maxgap);
    int g;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      uart_rx_data  = q[i];
      uart_rx_valid = 1'b1;
      g = (i == q.size() - 1) ? 0 : int'($urandom_range(maxgap, 0));
      if (g > 0) begin
        @(negedge clk);
        uart_rx_valid = 1'b0;
        repeat (g - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic start_load(input string tag);
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    chk({tag, "_mode_after_start"}, boot_mode, 1);
    chk({tag, "_wl_cleared"}, words_loaded, 0);
    chk({tag, "_flags_cleared"}, {boot_done, boot_error}, 0);
  endtask

  task automatic do_load(input string tag, input int n, input bq_t d, input int maxgap);
    bq_t q;
    logic [DW-1:0] w;
    hdr(n, q);
    foreach (d[i]) q.push_back(d[i]);
    wq.delete();
    start_load(tag);
    send_bytes(q, maxgap);
    chk({tag, "_last_wr_latency"}, boot_mem_wr_en, 1);
    chk({tag, "_mode_in_last_wr"}, boot_mode, 1);
    @(negedge clk);
    chk({tag, "_mode_falls"}, boot_mode, 0);
    chk({tag, "_done"}, {boot_done, boot_error, boot_mem_wr_en}, 3'b100);
    chk({tag, "_words_loaded"}, words_loaded, n);
    chk({tag, "_num_writes"}, wq.size(), n);
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int b = 0; b < BPW; b++) w[8*b +: 8] = d[i*BPW + b];
      if (i < wq.size()) begin
        chk({tag, "_addr"}, wq[i].addr, i);
        chk({tag, "_data"}, wq[i].data, w);
        chk({tag, "_wl_at_wr"}, wq[i].wl, i + 1);
        chk({tag, "_mode_at_wr"}, wq[i].bm, 1);
      end
    end
  endtask

  initial begin
    bq_t q, d;
    int  n;

    repeat (3) @(negedge clk);
    chk("rst_mode", boot_mode, 0);
    chk("rst_wr_en", boot_mem_wr_en, 0);
    chk("rst_addr", boot_mem_addr, 0);
    chk("rst_data", boot_mem_rd_data, 0);
    chk("rst_flags", {boot_done, boot_error}, 0);
    chk("rst_wl", words_loaded, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray bytes in IDLE must be ignored.
    q = {8'h05, 8'h00, 8'h00, 8'h00};
    send_bytes(q, 0);
    chk("idle_ignores_rx", {boot_mode, boot_done, boot_error, boot_mem_wr_en}, 0);

    d = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load("dir", 2, d, 2);
    if (wq.size() == 2) begin
      chk("dir_word0_const", wq[0].data, 32'h12345678);
      chk("dir_word1_const", wq[1].data, 32'hDEADBEEF);
    end

    // Zero-length load.
    wq.delete();
    start_load("zero");
    hdr(0, q);
    send_bytes(q, 1);
    chk("zero_done", {boot_done, boot_error, boot_mode}, 3'b100);
    @(negedge clk);
    chk("zero_no_writes", wq.size(), 0);
    chk("zero_wl", words_loaded, 0);
    chk("dir_addr_hold", boot_mem_addr, 1);
    chk("dir_data_hold", boot_mem_rd_data, 32'hDEADBEEF);

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(6, 1));
      gen_payload(n, d);
      do_load("rnd", n, d, 2);
    end
    // Fully back-to-back bytes: each next-word byte lands in a strobe cycle.
    for (int r = 0; r < 2; r++) begin
      n = int'($urandom_range(7, 3));
      gen_payload(n, d);
      do_load("b2b", n, d, 0);
    end

    // Timeout after one full word plus two bytes of a second.
    wq.delete();
    start_load("tmo");
    hdr(3, q);
    gen_payload(1, d);
    foreach (d[i]) q.push_back(d[i]);
    q.push_back(8'hA5);
    q.push_back(8'h5A);
    send_bytes(q, 1);
    repeat (TO - 1) @(negedge clk);
    chk("tmo_not_yet", {boot_error, boot_mode}, 2'b01);
    @(negedge clk);
    chk("tmo_error", {boot_error, boot_mode, boot_done}, 3'b100);
    chk("tmo_num_writes", wq.size(), 1);
    if (wq.size() >= 1) begin
      chk("tmo_addr", wq[0].addr, 0);
      chk("tmo_data", wq[0].data, {d[3], d[2], d[1], d[0]});
    end
    repeat (3) @(negedge clk);
    chk("tmo_no_late_write", wq.size(), 1);

    // Oversize header.
    wq.delete();
    start_load("big");
    hdr(32'(MAXW + 1), q);
    send_bytes(q, 1);
    chk("big_error", {boot_error, boot_mode, boot_done}, 3'b100);
    @(negedge clk);
    chk("big_no_writes", wq.size(), 0);

    // Exactly MAX_WORDS is accepted; the load then times out idle.
    start_load("max");
    hdr(32'(MAXW), q);
    send_bytes(q, 1);
    chk("max_accepted", {boot_mode, boot_error, boot_done}, 3'b100);
    repeat (TO) @(negedge clk);
    chk("max_idle_timeout", {boot_error, boot_mode}, 2'b10);

    // Reset in the middle of DATA after three words.
    wq.delete();
    start_load("mid");
    hdr(5, q);
    gen_payload(5, d);
    for (int i = 0; i < 3 * BPW + 2; i++) q.push_back(d[i]);
    send_bytes(q, 1);
    chk("mid_wl3", words_loaded, 3);
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    chk("mid_start_ignored", {boot_mode, boot_done, boot_error}, 3'b100);
    chk("mid_start_keeps_wl", words_loaded, 3);
    wq.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {boot_mode, boot_mem_wr_en, boot_done, boot_error}, 0);
    chk("mid_rst_addr_data", {boot_mem_addr, boot_mem_rd_data}, 0);
    chk("mid_rst_wl", words_loaded, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_write_release", wq.size(), 0);
    chk("mid_idle_after", {boot_mode, boot_done, boot_error}, 0);
    gen_payload(1, d);
    do_load("post_rst", 1, d, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
